// File: rtl/codemem_wr_arb.sv
// codemem_wr_arb: arbitrates the code-memory write port between two burst loaders
// and a full-memory clear sweep; all write outputs are registered.
module codemem_wr_arb #(
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int CODE_DATA_WIDTH = 64,
    parameter logic [CODE_DATA_WIDTH-1:0] CLEAR_WORD = 64'h0006_0000_0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       hold_i,
    input  logic                       clear_req_i,
    output logic                       clear_busy_o,
    output logic                       clear_done_o,
    input  logic                       s0_valid_i,
    output logic                       s0_ready_o,
    input  logic [CODE_ADDR_WIDTH-1:0] s0_addr_i,
    input  logic [CODE_DATA_WIDTH-1:0] s0_data_i,
    input  logic                       s0_last_i,
    input  logic                       s1_valid_i,
    output logic                       s1_ready_o,
    input  logic [CODE_ADDR_WIDTH-1:0] s1_addr_i,
    input  logic [CODE_DATA_WIDTH-1:0] s1_data_i,
    input  logic                       s1_last_i,
    output logic [1:0]                 grant_o,
    output logic [CODE_ADDR_WIDTH-1:0] code_mem_wr_addr_o,
    output logic [CODE_DATA_WIDTH-1:0] code_mem_wr_data_o,
    output logic                       code_mem_wr_en_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, CLEAR} state_t;
    localparam logic [CODE_ADDR_WIDTH-1:0] CNT_MAX = '1;

    state_t                     state_q, state_d;
    logic                       pend_q, pend_d;
    logic                       last_q, last_d;
    logic [CODE_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                       en_q, en_d;
    logic                       done_q, done_d;
    logic [CODE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CODE_DATA_WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q || (clear_req_i && state_q != CLEAR);
        last_d  = last_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (!hold_i) begin
                    // a pending clear outranks both loaders; a fresh request this cycle re-arms it
                    if (pend_q) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                        pend_d  = clear_req_i;
                    end else if (s0_valid_i && s1_valid_i) begin
                        state_d = last_q ? GNT0 : GNT1;
                    end else if (s0_valid_i) begin
                        state_d = GNT0;
                    end else if (s1_valid_i) begin
                        state_d = GNT1;
                    end
                end
            end
            GNT0: begin
                if (s0_valid_i) begin
                    en_d   = 1'b1;
                    addr_d = s0_addr_i;
                    data_d = s0_data_i;
                    if (s0_last_i) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end
                end
            end
            GNT1: begin
                if (s1_valid_i) begin
                    en_d   = 1'b1;
                    addr_d = s1_addr_i;
                    data_d = s1_data_i;
                    if (s1_last_i) begin
                        state_d = IDLE;
                        last_d  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                en_d   = 1'b1;
                addr_d = cnt_q;
                data_d = CLEAR_WORD;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s0_ready_o         = state_q == GNT0;
    assign s1_ready_o         = state_q == GNT1;
    assign grant_o            = {state_q == GNT1, state_q == GNT0};
    assign clear_busy_o       = pend_q || state_q == CLEAR;
    assign clear_done_o       = done_q;
    assign code_mem_wr_en_o   = en_q;
    assign code_mem_wr_addr_o = addr_q;
    assign code_mem_wr_data_o = data_q;
endmodule

// File: tb/tb_codemem_wr_arb.sv
// tb_codemem_wr_arb: directed scenarios with random payloads, checked against an
// expected write log built from arbitration rules (tie winner, clear sweep, latency).
module tb_codemem_wr_arb;
    localparam logic [63:0] CW = 64'h0006_0000_0000_0000;

    typedef struct {
        logic [9:0]  a;
        logic [63:0] d;
        logic        done;
        int          cyc;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i, hold_i, clear_req_i;
    logic        s0_valid_i, s0_last_i, s1_valid_i, s1_last_i;
    logic [9:0]  s0_addr_i, s1_addr_i;
    logic [63:0] s0_data_i, s1_data_i;
    logic        clear_busy_o, clear_done_o, s0_ready_o, s1_ready_o, code_mem_wr_en_o;
    logic [1:0]  grant_o;
    logic [9:0]  code_mem_wr_addr_o;
    logic [63:0] code_mem_wr_data_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ovl = 0;
    int stray = 0;
    int lw;
    wr_t logq[$], expq[$], sent0[$], sent1[$];

    codemem_wr_arb dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .hold_i(hold_i), .clear_req_i(clear_req_i),
        .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o),
        .s0_valid_i(s0_valid_i), .s0_ready_o(s0_ready_o), .s0_addr_i(s0_addr_i),
        .s0_data_i(s0_data_i), .s0_last_i(s0_last_i),
        .s1_valid_i(s1_valid_i), .s1_ready_o(s1_ready_o), .s1_addr_i(s1_addr_i),
        .s1_data_i(s1_data_i), .s1_last_i(s1_last_i),
        .grant_o(grant_o), .code_mem_wr_addr_o(code_mem_wr_addr_o),
        .code_mem_wr_data_o(code_mem_wr_data_o), .code_mem_wr_en_o(code_mem_wr_en_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (code_mem_wr_en_o) logq.push_back('{code_mem_wr_addr_o, code_mem_wr_data_o, clear_done_o, cyc});
        if (clear_done_o && !code_mem_wr_en_o) stray <= stray + 1;
        if (grant_o == 2'b11) ovl <= ovl + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [127:0] pk(input wr_t w);
        return {21'b0, w.a, w.d, w.done, 32'(w.cyc)};
    endfunction

    function automatic wr_t sent_at(input int p, input int i);
        return (p == 0) ? sent0[i] : sent1[i];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_q(input int p, input int from, input int to);
        for (int i = from; i <= to; i++) expq.push_back(sent_at(p, i));
    endtask

    task automatic check_log(input string tag);
        repeat (3) @(negedge clk_i);
        chk({tag, "_cnt"}, 128'(logq.size()), 128'(expq.size()));
        for (int i = 0; i < logq.size() && i < expq.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), pk(logq[i]), pk(expq[i]));
        logq.delete();
        expq.delete();
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        lw = 1;
    endtask

    // fixed: addresses 5.. and data 'hA..; gap: max idle cycles inserted between beats
    task automatic send(input int p, input int n, input bit fixed, input bit last_en, input int gap);
        for (int i = 0; i < n; i++) begin
            logic [9:0]  a;
            logic [63:0] d;
            int          w;
            a = fixed ? 10'(5 + i) : 10'($urandom);
            d = fixed ? 64'(10 + i) : {$urandom, $urandom};
            if (gap > 0 && i > 0) begin
                if (p == 0) s0_valid_i = 1'b0; else s1_valid_i = 1'b0;
                repeat ($urandom_range(0, gap)) @(negedge clk_i);
            end
            if (p == 0) begin
                s0_valid_i = 1'b1; s0_addr_i = a; s0_data_i = d; s0_last_i = last_en && i == n - 1;
            end else begin
                s1_valid_i = 1'b1; s1_addr_i = a; s1_data_i = d; s1_last_i = last_en && i == n - 1;
            end
            w = 0;
            while (!((p == 0) ? s0_ready_o : s1_ready_o) && w < 3000) begin
                @(negedge clk_i);
                w++;
            end
            total++;
            assert (w < 3000) else begin
                bad++;
                $error("FAIL send_timeout p=%0d waited=%0d limit=3000", p, w);
            end
            if (w >= 3000) break;
            if (p == 0) sent0.push_back('{a, d, 1'b0, cyc + 1});
            else sent1.push_back('{a, d, 1'b0, cyc + 1});
            @(negedge clk_i);
        end
        if (p == 0) begin s0_valid_i = 1'b0; s0_last_i = 1'b0; end
        else begin s1_valid_i = 1'b0; s1_last_i = 1'b0; end
    endtask

    initial begin
        int c, fst, sec, it;
        rst_n_i = 1'b0; hold_i = 1'b0; clear_req_i = 1'b0;
        s0_valid_i = 1'b0; s0_last_i = 1'b0; s0_addr_i = '0; s0_data_i = '0;
        s1_valid_i = 1'b0; s1_last_i = 1'b0; s1_addr_i = '0; s1_data_i = '0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        lw = 1;
        chk("rst_grant", 128'(grant_o), 128'(0));
        chk("rst_wr_en", 128'(code_mem_wr_en_o), 128'(0));
        chk("rst_addr_data", 128'({code_mem_wr_addr_o, code_mem_wr_data_o}), 128'(0));
        chk("rst_misc", 128'({clear_busy_o, clear_done_o, s0_ready_o, s1_ready_o}), 128'(0));
        logq.delete();

        // single s0 burst, addresses/data used verbatim, latency 1 after each accept
        c = cyc;
        fork
            send(0, 3, 1'b1, 1'b1, 0);
            begin @(negedge clk_i); #1; chk("t1_grant", 128'(grant_o), 128'(2'b01)); end
        join
        chk("t1_grant_end", 128'(grant_o), 128'(0));
        for (int i = 0; i < 3; i++) expq.push_back('{10'(5 + i), 64'(10 + i), 1'b0, c + 2 + i});
        lw = 0;
        check_log("t1");

        // ties from reset: requester that did not win last goes first, one idle cycle between
        do_reset();
        sent0.delete(); sent1.delete(); logq.delete();
        for (int r = 0; r < 2; r++) begin
            fst = (lw == 1) ? 0 : 1;
            sec = 1 - fst;
            fork
                send(0, 2, 1'b0, 1'b1, 0);
                send(1, 2, 1'b0, 1'b1, 0);
            join
            chk($sformatf("t2_gap%0d", r), 128'(sent_at(sec, 2 * r).cyc - sent_at(fst, 2 * r + 1).cyc), 128'(2));
            add_q(fst, 2 * r, 2 * r + 1);
            add_q(sec, 2 * r, 2 * r + 1);
            lw = sec;
        end
        check_log("t2");

        // s1 arrives mid-burst; s0 keeps the port even across valid gaps
        sent0.delete(); sent1.delete();
        fork
            send(0, 4, 1'b0, 1'b1, 2);
            begin wait (sent0.size() >= 1); @(negedge clk_i); send(1, 2, 1'b0, 1'b1, 0); end
            begin
                wait (sent0.size() >= 1);
                it = 0;
                while (it < 5000) begin
                    @(negedge clk_i); #1;
                    it++;
                    if (sent0.size() == 4 && sent0[3].cyc <= cyc) break;
                    chk("t3_grant", 128'(grant_o), 128'(2'b01));
                    chk("t3_s1_ready", 128'(s1_ready_o), 128'(0));
                end
            end
        join
        add_q(0, 0, 3);
        add_q(1, 0, 1);
        lw = 1;
        check_log("t3");

        // clear request during a burst: burst completes, full sweep, then s1
        sent0.delete(); sent1.delete();
        fork
            send(0, 4, 1'b0, 1'b1, 0);
            begin
                wait (sent0.size() >= 2);
                clear_req_i = 1'b1;
                @(negedge clk_i);
                clear_req_i = 1'b0;
                #1 chk("t4_busy", 128'(clear_busy_o), 128'(1));
            end
            begin wait (sent0.size() >= 2); repeat (2) @(negedge clk_i); send(1, 2, 1'b0, 1'b1, 0); end
        join
        add_q(0, 0, 3);
        for (int i = 0; i < 1024; i++) expq.push_back('{10'(i), CW, i == 1023, sent0[3].cyc + 2 + i});
        add_q(1, 0, 1);
        lw = 1;
        chk("t4_busy_end", 128'(clear_busy_o), 128'(0));
        check_log("t4");

        // hold blocks a new grant but not a burst already owned
        sent0.delete(); sent1.delete();
        hold_i = 1'b1;
        s0_valid_i = 1'b1; s0_addr_i = 10'($urandom); s0_data_i = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i); #1;
            chk($sformatf("t5_hold_grant%0d", i), 128'(grant_o), 128'(0));
            chk($sformatf("t5_hold_wr%0d", i), 128'(logq.size()), 128'(0));
        end
        hold_i = 1'b0;
        fork
            send(0, 3, 1'b0, 1'b1, 0);
            begin wait (sent0.size() >= 1); @(negedge clk_i); hold_i = 1'b1; end
        join
        hold_i = 1'b0;
        add_q(0, 0, 2);
        lw = 0;
        check_log("t5");

        // reset in the middle of an s1 burst, then a tie goes to s0
        sent0.delete(); sent1.delete();
        send(1, 2, 1'b0, 1'b0, 0);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        lw = 1;
        #1;
        chk("t6_wr_en", 128'(code_mem_wr_en_o), 128'(0));
        chk("t6_grant", 128'(grant_o), 128'(0));
        fst = (lw == 1) ? 0 : 1;
        fork
            send(0, 1, 1'b0, 1'b1, 0);
            send(1, 1, 1'b0, 1'b1, 0);
        join
        add_q(1, 0, 1);
        add_q(fst, fst == 0 ? 0 : 2, fst == 0 ? 0 : 2);
        add_q(1 - fst, fst == 0 ? 2 : 0, fst == 0 ? 2 : 0);
        check_log("t6");

        chk("grant_overlap", 128'(ovl), 128'(0));
        chk("stray_clear_done", 128'(stray), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/codemem_wr_arb.md
Name: codemem_wr_arb

Overview:
- Owns the single code-memory write port of the BPF core and shares it between two program loaders.
- Requester 0 is the register/strobe loader; requester 1 is the stream/DMA loader.
- Each loader delivers a program as a burst of beats ending in `last`. A burst is granted atomically, so programs from the two sources never interleave.
- Also provides a hardware clear sweep that fills all of code memory with a safe "ret #0" word, and blocks new grants while the CPU is running.

Parameters:
- CODE_ADDR_WIDTH, 10, code memory address width; depth = 2^CODE_ADDR_WIDTH.
- CODE_DATA_WIDTH, 64, instruction width.
- CLEAR_WORD, 64'h0006_0000_0000_0000, word written by the clear sweep (BPF ret #0).

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- hold  in  1  CPU running; while high, no new grant or clear sweep starts.
- clear_req  in  1  single-cycle pulse requesting a clear sweep.
- clear_busy  out  1  clear pending or sweep in progress.
- clear_done  out  1  one-cycle pulse, coincident with the final clear write.
- s0_valid / s1_valid  in  1  requester beat valid.
- s0_ready / s1_ready  out  1  requester beat accepted when valid && ready.
- s0_addr / s1_addr  in  CODE_ADDR_WIDTH  beat write address.
- s0_data / s1_data  in  CODE_DATA_WIDTH  beat write data.
- s0_last / s1_last  in  1  final beat of the burst.
- grant  out  2  one-hot current owner; bit n = requester n; 0 when idle or clearing.
- code_mem_wr_addr  out  CODE_ADDR_WIDTH  registered write address.
- code_mem_wr_data  out  CODE_DATA_WIDTH  registered write data.
- code_mem_wr_en  out  1  registered write enable.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; all outputs 0, including code_mem_wr_addr, code_mem_wr_data and code_mem_wr_en.
  - clear_pend=0; sweep counter=0; last_winner=1, so requester 0 wins the first tie.
  - Reset mid-burst or mid-sweep aborts immediately. No further writes occur, and any partially written memory is left as is.
- States:
  - IDLE, GNT0, GNT1, CLEAR.
  - grant = {state==GNT1, state==GNT0}.
- clear_req handling:
  - Sets clear_pend in any state except CLEAR; ignored in CLEAR.
  - clear_busy = clear_pend || state==CLEAR.
- IDLE (hold is evaluated every cycle):
  - If hold=1: stay in IDLE.
  - Else if clear_pend: go to CLEAR, counter=0, clear_pend cleared. Clear has priority over both requesters.
  - Else if exactly one sN_valid: go to GNTn.
  - Else if both valid: round-robin; the requester that is not last_winner wins.
  - sN_ready=0 in IDLE, so the first beat is accepted at the earliest 1 cycle after valid is first seen.
- GNTn:
  - sN_ready = 1 for the owner only; the other requester's ready is 0.
  - hold does not interrupt an owned burst.
  - On accept: next cycle code_mem_wr_en=1 with code_mem_wr_addr/code_mem_wr_data = the accepted beat (latency 1). The address is used verbatim; there is no auto-increment.
  - Cycles with no accept give code_mem_wr_en=0 next cycle; the address/data registers keep their values.
  - Accept with sN_last=1: go to IDLE and set last_winner=n. Back-to-back bursts from the same requester therefore incur one idle cycle.
- CLEAR:
  - Each cycle registers code_mem_wr_en=1, code_mem_wr_addr=counter, code_mem_wr_data=CLEAR_WORD, then counter+1.
  - When counter == 2^CODE_ADDR_WIDTH-1: clear_done=1 in the same cycle as that write's code_mem_wr_en, then go to IDLE. The counter wraps to 0.
  - Both readies are 0 throughout; a sweep takes exactly 2^CODE_ADDR_WIDTH write cycles.
  - hold rising mid-sweep does not stop the sweep.
- Simultaneous events:
  - clear_req arriving in the same cycle as a requester's last beat is latched; CLEAR follows via IDLE.
  - valid may drop mid-burst: the grant is held until the last beat is accepted. A requester that never asserts last owns the port indefinitely; this is by design, and software must terminate bursts.
- Only one source can own the port at a time, so code_mem_wr_en is never driven by two sources.

Test Plan:
1. After reset, s0 sends 3 beats, addr 5,6,7, data 'hA,'hB,'hC, last on the third, valid held continuously. Required: grant=01 one cycle after valid; three consecutive wr_en cycles with matching addr/data, each 1 cycle after its accept; grant=00 after the third accept.
2. s0_valid and s1_valid asserted in the same cycle from reset, 2 beats each. Required: s0 burst completes first, one idle cycle, then s1 burst. Repeat the tie: s0 wins again (last_winner=1).
3. s1_valid raised during s0's 4-beat burst. Required: s1_ready=0 and grant=01 until s0_last is accepted; no s1 write occurs between s0 writes.
4. clear_req pulse during s0 beat 2 of 4. Required: clear_busy=1 immediately; s0 finishes; then 1024 consecutive wr_en cycles with addr 0..1023 and data 64'h0006000000000000; clear_done is high only on the addr=1023 write; s1 pending traffic stays blocked until after the sweep.
5. hold=1 with s0_valid=1. Required: grant stays 00, no writes. Then drop hold, grant s0, and raise hold after beat 1. Required: the burst still completes all beats.
6. rst_n=0 for one cycle after beat 2 of a 4-beat s1 burst. Required: wr_en=0 and grant=00 in the following cycle; no further s1 writes; the next s0/s1 tie goes to s0.
